sub_frame_acc: RTL and testbench



---
 rtl/sub_pkg.sv | 17 +
 rtl/sub_sat_add.sv | 34 +++
 rtl/sub_frame_acc.sv | 119 +++++++++++
 tb/tb_sub_frame_acc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the subtractor-result accumulation stages.
package sub_pkg;

  localparam int unsigned SAMPLE_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

endpackage

// File: rtl/sub_sat_add.sv
// Combinational signed adder with overflow flag; clamps to the signed range
// when SUB_FRAME_ACC_SAT_EN is defined, otherwise wraps.
module sub_sat_add
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] sum_o,
  output logic                    ovf_o
);

`ifdef SUB_FRAME_ACC_SAT_EN
  localparam logic signed [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic signed [WIDTH-1:0] raw;
  logic                    ovf;

  always_comb begin
    raw = a_i + b_i;
    // Overflow only possible when both operands share a sign.
    ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
    ovf_o = ovf;
`ifdef SUB_FRAME_ACC_SAT_EN
    sum_o = ovf ? (a_i[WIDTH-1] ? NEG_LIM : POS_LIM) : raw;
`else
    sum_o = raw;
`endif
  end

endmodule

// File: rtl/sub_frame_acc.sv
// Frame accumulator for the signed subtractor result stream: sum/min/max/ovf
// per FRAME_LEN samples. Saturating sum when SUB_FRAME_ACC_SAT_EN is defined.
module sub_frame_acc
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_sum,
  output logic signed [WIDTH-1:0] out_min,
  output logic signed [WIDTH-1:0] out_max,
  output logic                    out_ovf
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_PRE = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0] sum_q, sum_d;
  logic signed [WIDTH-1:0] min_q, min_d;
  logic signed [WIDTH-1:0] max_q, max_d;
  logic                    ovf_q, ovf_d;

  logic signed [WIDTH-1:0] add_sum;
  logic                    add_ovf;

  sub_sat_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i   (sum_q),
    .b_i   (in_data),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    // clear outranks both the input accept and the output handshake.
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sum_d   = in_data;
            min_d   = in_data;
            max_d   = in_data;
            ovf_d   = 1'b0;
            cnt_d   = CNT_ONE;
            state_d = (FRAME_LEN == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            sum_d = add_sum;
            ovf_d = ovf_q | add_ovf;
            if (in_data < min_q) min_d = in_data;
            if (in_data > max_q) max_d = in_data;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_PRE) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sub_frame_acc.sv
// Bench for sub_frame_acc (WIDTH=64, FRAME_LEN=4), wrap or saturating build.
module tb_sub_frame_acc;

  localparam logic signed [63:0] P62  = 64'sh4000_0000_0000_0000;
  localparam logic signed [63:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] MINV = 64'sh8000_0000_0000_0000;

`ifdef SUB_FRAME_ACC_SAT_EN
  localparam logic signed [63:0] E_P62 = MAXV;
  localparam logic signed [63:0] E_NEG = MINV;
  localparam logic signed [63:0] E_TOP = MAXV - 64'sd1;
`else
  localparam logic signed [63:0] E_P62 = MINV;
  localparam logic signed [63:0] E_NEG = 64'sd0;
  localparam logic signed [63:0] E_TOP = MAXV;
`endif

  typedef struct {
    logic signed [63:0] sum;
    logic signed [63:0] mn;
    logic signed [63:0] mx;
    logic               ovf;
  } res_t;

  typedef struct {
    logic [3:0][63:0] s;
    bit               gap;
    res_t             exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [63:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [63:0] out_sum;
  logic signed [63:0] out_min;
  logic signed [63:0] out_max;
  logic               out_ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;
  res_t        exp_q[$];
  res_t        mon_e;
  vec_t        vecs[7];

  sub_frame_acc #(
    .WIDTH     (64),
    .FRAME_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  function automatic res_t mkr(input logic signed [63:0] s, input logic signed [63:0] mn,
                               input logic signed [63:0] mx, input logic o);
    res_t r;
    r.sum = s; r.mn = mn; r.mx = mx; r.ovf = o;
    return r;
  endfunction

  function automatic vec_t mk(input logic signed [63:0] a, input logic signed [63:0] b,
                              input logic signed [63:0] c, input logic signed [63:0] d,
                              input bit g, input res_t e);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.gap = g;
    v.exp = e;
    return v;
  endfunction

  // Scoreboard: every completed output handshake pops one expected frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got out_valid=1 sum=%0d required no pending frame", out_sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame_sum", out_sum, mon_e.sum);
        chk("frame_min", out_min, mon_e.mn);
        chk("frame_max", out_max, mon_e.mx);
        chk1("frame_ovf", out_ovf, mon_e.ovf);
      end
    end
  end

  task automatic send(input logic signed [63:0] s);
    int unsigned n;
    logic rdy;
    n = 0;
    in_valid = 1'b1;
    in_data  = s;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=0 for 50 cycles required 1");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = mk(64'sd5, -64'sd3, 64'sd10, -64'sd1, 1'b0, mkr(64'sd11, -64'sd3, 64'sd10, 1'b0));
    vecs[1] = mk(64'sd1, 64'sd2, 64'sd3, 64'sd4, 1'b0, mkr(64'sd10, 64'sd1, 64'sd4, 1'b0));
    vecs[2] = mk(P62, P62, 64'sd0, 64'sd0, 1'b0, mkr(E_P62, 64'sd0, P62, 1'b1));
    vecs[3] = mk(MINV, MINV, MINV, MINV, 1'b0, mkr(E_NEG, MINV, MINV, 1'b1));
    vecs[4] = mk(MAXV, 64'sd1, -64'sd1, 64'sd0, 1'b0, mkr(E_TOP, -64'sd1, MAXV, 1'b1));
    vecs[5] = mk(-64'sd1, -64'sd2, -64'sd3, -64'sd4, 1'b1, mkr(-64'sd10, -64'sd4, -64'sd1, 1'b0));
    vecs[6] = mk(-64'sd1, -64'sd2, -64'sd3, -64'sd4, 1'b0, mkr(-64'sd10, -64'sd4, -64'sd1, 1'b0));

    #2;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", out_sum, 64'sd0);
    chk("rst_min", out_min, 64'sd0);
    chk("rst_max", out_max, 64'sd0);
    chk1("rst_ovf", out_ovf, 1'b0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].exp);
      for (int k = 0; k < 4; k++) begin
        send($signed(vecs[i].s[k]));
        if (vecs[i].gap && k < 3) tick();
      end
      chk1("valid_after_last", out_valid, 1'b1);
      chk1("ready_low_hold", in_ready, 1'b0);
      tick();
      chk1("valid_drop", out_valid, 1'b0);
      chk1("ready_back", in_ready, 1'b1);
    end

    // Back-pressure: result held while the sink stalls, input ignored.
    out_ready = 1'b0;
    exp_q.push_back(mkr(64'sd10, 64'sd1, 64'sd4, 1'b0));
    send(64'sd1); send(64'sd2); send(64'sd3); send(64'sd4);
    in_valid = 1'b1;
    in_data  = 64'sd77;
    for (int c = 0; c < 5; c++) begin
      chk1("stall_valid", out_valid, 1'b1);
      chk1("stall_ready", in_ready, 1'b0);
      chk("stall_sum", out_sum, 64'sd10);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk1("stall_release", out_valid, 1'b0);
    exp_q.push_back(mkr(64'sd4, 64'sd1, 64'sd1, 1'b0));
    send(64'sd1); send(64'sd1); send(64'sd1); send(64'sd1);
    tick();

    // clear mid-frame: partial frame and the clear-cycle sample are dropped.
    send(P62); send(P62);
    chk1("ovf_mid_frame", out_ovf, 1'b1);
    in_valid = 1'b1;
    in_data  = 64'sd99;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk1("clear_ovf", out_ovf, 1'b0);
    chk1("clear_valid", out_valid, 1'b0);
    chk1("clear_ready", in_ready, 1'b1);
    exp_q.push_back(mkr(64'sd4, 64'sd1, 64'sd1, 1'b0));
    send(64'sd1); send(64'sd1); send(64'sd1); send(64'sd1);
    tick();

    // clear during HOLD wins over out_ready; the frame is never delivered.
    out_ready = 1'b0;
    send(64'sd1); send(64'sd2); send(64'sd3); send(64'sd4);
    chk1("hold_before_clear", out_valid, 1'b1);
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    chk1("hold_clear_valid", out_valid, 1'b0);
    chk1("hold_clear_ready", in_ready, 1'b1);

    // Asynchronous reset while holding a result.
    out_ready = 1'b0;
    send(64'sd5); send(64'sd6); send(64'sd7); send(64'sd8);
    chk1("hold_before_rst", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", out_valid, 1'b0);
    chk1("async_rst_ready", in_ready, 1'b1);
    chk("async_rst_sum", out_sum, 64'sd0);
    chk("async_rst_min", out_min, 64'sd0);
    chk("async_rst_max", out_max, 64'sd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(mkr(64'sd10, 64'sd1, 64'sd4, 1'b0));
    send(64'sd1); send(64'sd2); send(64'sd3); send(64'sd4);
    tick();
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_frames: got %0d undelivered required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
